// File: rtl/tt_um_prbs_checker.sv
// PRBS-7 (x^7+x^6+1) serial stream checker: hunts for a seed, verifies SYNC_LEN bits, then counts errors.
// Optional macro PRBS_CHK_LOCKLOSS_EN drops lock after 8 errors inside one 64-bit window.
module tt_um_prbs_checker #(
    parameter int SYNC_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        UNUSED = 2'd3
    } state_t;

    state_t     r_state;
    logic [6:0] r_sr;
    logic [2:0] r_fill;
    logic [5:0] r_match;
    logic [7:0] r_err_cnt;
    logic       r_err_pulse;

    state_t     w_state_nxt;
    logic [6:0] w_sr_nxt;
    logic [2:0] w_fill_nxt;
    logic [5:0] w_match_nxt;
    logic [7:0] w_err_cnt_nxt;
    logic       w_err_pulse_nxt;

    logic       w_bit;
    logic       w_valid;
    logic       w_clr;
    logic       w_pred;
    logic       w_mismatch;
    logic [6:0] w_sr_shift;
    logic [2:0] w_fill_inc;
    logic [7:0] w_err_inc;
    logic       w_unused;

    assign w_bit      = ui_in[0];
    assign w_valid    = ui_in[1];
    assign w_clr      = ui_in[2];
    assign w_pred     = r_sr[6] ^ r_sr[5];
    assign w_mismatch = w_bit ^ w_pred;
    assign w_sr_shift = {r_sr[5:0], w_bit};
    assign w_fill_inc = (r_fill == 3'd7) ? 3'd7 : r_fill + 3'd1;
    assign w_err_inc  = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;
    assign w_unused   = ^{ena, uio_in, ui_in[7:3]};

`ifdef PRBS_CHK_LOCKLOSS_EN
    logic [5:0] r_win_cnt;
    logic [3:0] r_win_err;
    logic [5:0] w_win_cnt_nxt;
    logic [3:0] w_win_err_nxt;
    logic [3:0] w_win_err_inc;

    assign w_win_err_inc = r_win_err + {3'b000, w_mismatch};
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_sr_nxt        = r_sr;
        w_fill_nxt      = r_fill;
        w_match_nxt     = r_match;
        w_err_cnt_nxt   = r_err_cnt;
        w_err_pulse_nxt = 1'b0;
`ifdef PRBS_CHK_LOCKLOSS_EN
        w_win_cnt_nxt   = r_win_cnt;
        w_win_err_nxt   = r_win_err;
`endif
        case (r_state)
            HUNT: begin
                if (w_valid) begin
                    w_sr_nxt   = w_sr_shift;
                    w_fill_nxt = w_fill_inc;
                    // An all-zero register is the LFSR lockup state and never seeds a search.
                    if (w_fill_inc == 3'd7 && w_sr_shift != 7'd0) begin
                        w_state_nxt = VERIFY;
                        w_match_nxt = 6'd0;
                    end
                end
            end
            VERIFY: begin
                if (w_valid) begin
                    w_sr_nxt = w_sr_shift;
                    if (w_mismatch) begin
                        w_state_nxt = HUNT;
                        w_fill_nxt  = 3'd0;
                        w_match_nxt = 6'd0;
                    end else if (r_match == 6'(SYNC_LEN - 1)) begin
                        w_state_nxt = LOCKED;
                        w_match_nxt = 6'd0;
`ifdef PRBS_CHK_LOCKLOSS_EN
                        w_win_cnt_nxt = 6'd0;
                        w_win_err_nxt = 4'd0;
`endif
                    end else begin
                        w_match_nxt = r_match + 6'd1;
                    end
                end
            end
            LOCKED: begin
                if (w_valid) begin
                    // Free-running on the prediction so a corrupted bit cannot poison later ones.
                    w_sr_nxt = {r_sr[5:0], w_pred};
                    if (w_mismatch) begin
                        w_err_pulse_nxt = 1'b1;
                        w_err_cnt_nxt   = w_err_inc;
                    end
`ifdef PRBS_CHK_LOCKLOSS_EN
                    if (w_win_err_inc == 4'd8) begin
                        w_state_nxt = HUNT;
                        w_fill_nxt  = 3'd0;
                    end else if (r_win_cnt == 6'd63) begin
                        w_win_cnt_nxt = 6'd0;
                        w_win_err_nxt = 4'd0;
                    end else begin
                        w_win_cnt_nxt = r_win_cnt + 6'd1;
                        w_win_err_nxt = w_win_err_inc;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_fill_nxt  = 3'd0;
                w_match_nxt = 6'd0;
            end
        endcase
        if (w_clr) begin
            w_err_cnt_nxt = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_sr        <= 7'd0;
            r_fill      <= 3'd0;
            r_match     <= 6'd0;
            r_err_cnt   <= 8'd0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_fill      <= w_fill_nxt;
            r_match     <= w_match_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_err_pulse <= w_err_pulse_nxt;
        end
    end

`ifdef PRBS_CHK_LOCKLOSS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_cnt <= 6'd0;
            r_win_err <= 4'd0;
        end else begin
            r_win_cnt <= w_win_cnt_nxt;
            r_win_err <= w_win_err_nxt;
        end
    end
`endif

    assign uo_out  = r_err_cnt;
    assign uio_out = {4'b0000, r_state, r_err_pulse, (r_state == LOCKED)};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_prbs_checker.sv
// Randomised and directed bench for tt_um_prbs_checker against a sequence-level PRBS-7 reference model.
module tb_tt_um_prbs_checker;
    localparam int SYNC_LEN = 16;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    // reference model: last seven bits of the checker's view of the sequence, oldest first
    int m_mode;
    bit m_hist[$];
    int m_fill;
    int m_match;
    int m_err;
    bit m_pulse;
    int m_win;
    int m_werr;
    // stimulus generator history, oldest first
    bit g_hist[$];

    tt_um_prbs_checker #(.SYNC_LEN(SYNC_LEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = 0; m_fill = 0; m_match = 0; m_err = 0; m_pulse = 0; m_win = 0; m_werr = 0;
        m_hist = {};
        for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
    endfunction

    function automatic void model_push(bit b);
        m_hist.push_back(b);
        m_hist.delete(0);
    endfunction

    function automatic void model_step(bit v, bit b, bit c);
        bit pred;
        bit any1;
        m_pulse = 1'b0;
        if (v) begin
            pred = m_hist[0] ^ m_hist[1];
            if (m_mode == 0) begin
                model_push(b);
                if (m_fill < 7) m_fill++;
                any1 = 1'b0;
                foreach (m_hist[k]) any1 |= m_hist[k];
                if (m_fill == 7 && any1) begin
                    m_mode = 1; m_match = 0;
                end
            end else if (m_mode == 1) begin
                model_push(b);
                if (b == pred) begin
                    m_match++;
                    if (m_match == SYNC_LEN) begin
                        m_mode = 2; m_win = 0; m_werr = 0;
                    end
                end else begin
                    m_mode = 0; m_fill = 0;
                end
            end else begin
                model_push(pred);
                if (b != pred) begin
                    m_pulse = 1'b1;
                    if (m_err < 255) m_err++;
                end
`ifdef PRBS_CHK_LOCKLOSS_EN
                m_win++;
                if (b != pred) m_werr++;
                if (m_werr == 8) begin
                    m_mode = 0; m_fill = 0;
                end else if (m_win == 64) begin
                    m_win = 0; m_werr = 0;
                end
`endif
            end
        end
        if (c) m_err = 0;
    endfunction

    function automatic void gen_reset();
        g_hist = {};
        for (int i = 0; i < 7; i++) g_hist.push_back(1'b1);
    endfunction

    function automatic bit gen_next();
        bit b;
        b = g_hist[0] ^ g_hist[1];
        g_hist.push_back(b);
        g_hist.delete(0);
        return b;
    endfunction

    task automatic check(input string tag);
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
        logic [1:0] mode2;
        exp_uo  = 8'(m_err);
        mode2   = 2'(m_mode);
        exp_uio = {4'b0000, mode2, m_pulse, (m_mode == 2)};
        total++;
        assert (uo_out === exp_uo) else begin
            bad++;
            $error("FAIL %s uo_out got %h want %h", tag, uo_out, exp_uo);
        end
        total++;
        assert (uio_out === exp_uio) else begin
            bad++;
            $error("FAIL %s uio_out got %h want %h", tag, uio_out, exp_uio);
        end
        total++;
        assert (uio_oe === 8'h0F) else begin
            bad++;
            $error("FAIL %s uio_oe got %h want 0f", tag, uio_oe);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic step(input bit v, input bit b, input bit c, input string tag);
        ui_in = {5'b00000, c, v, b};
        @(posedge clk);
        model_step(v, b, c);
        #1;
        check(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        @(posedge clk);
        model_reset();
        #1;
        check("reset");
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_uio", uio_out, 8'h00);
        rst_n = 1'b1;
    endtask

    // Seven seed ones then PRBS continuation; optional idle cycle before every valid bit.
    task automatic acquire(input bit toggle, input string tag);
        gen_reset();
        for (int i = 0; i < 23; i++) begin
            if (toggle) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, {tag, "_idle"});
            if (i == 22) chk({tag, "_prelock"}, {7'd0, uio_out[0]}, 8'd0);
            step(1'b1, (i < 7) ? 1'b1 : gen_next(), 1'b0, tag);
        end
        chk({tag, "_locked"}, {7'd0, uio_out[0]}, 8'd1);
        chk({tag, "_state"}, {6'd0, uio_out[3:2]}, 8'd2);
    endtask

    initial begin
        bit b;
        bit v;
        bit c;
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
        model_reset();
        gen_reset();
        do_reset();
        do_reset();

        // clean acquisition
        acquire(1'b0, "acq");
        chk("acq_uo", uo_out, 8'h00);

        // single bit error while locked
        b = gen_next();
        step(1'b1, ~b, 1'b0, "flip");
        chk("flip_pulse", {7'd0, uio_out[1]}, 8'd1);
        chk("flip_uo", uo_out, 8'd1);
        step(1'b1, gen_next(), 1'b0, "after_flip");
        chk("flip_pulse_gone", {7'd0, uio_out[1]}, 8'd0);
        for (int i = 0; i < 20; i++) step(1'b1, gen_next(), 1'b0, "clean");
        chk("clean_uo", uo_out, 8'd1);
        chk("clean_locked", {7'd0, uio_out[0]}, 8'd1);

        // random strobes, occasional errors and clears on a locked stream
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 19) == 0);
            if (v) b = gen_next() ^ ($urandom_range(0, 9) == 0);
            else   b = 1'($urandom_range(0, 1));
            step(v, b, c, "rand_lock");
        end

        // reset while locked forces full re-acquisition
        do_reset();
        chk("mid_reset_unlocked", {7'd0, uio_out[0]}, 8'd0);
        acquire(1'b0, "reacq");

        // all-zero stream is never accepted
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0, "zeros");
        chk("zeros_state", {6'd0, uio_out[3:2]}, 8'd0);
        chk("zeros_uo", uo_out, 8'd0);

        // random garbage through hunt/verify
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), "rand_hunt");

        // strobe toggling during acquisition
        do_reset();
        acquire(1'b1, "toggle");

`ifndef PRBS_CHK_LOCKLOSS_EN
        for (int i = 0; i < 300; i++) step(1'b1, ~gen_next(), 1'b0, "invert");
        chk("sat_uo", uo_out, 8'hFF);
        chk("sat_locked", {7'd0, uio_out[0]}, 8'd1);
        step(1'b1, ~gen_next(), 1'b1, "clear_on_err");
        chk("clear_uo", uo_out, 8'h00);
        chk("clear_locked", {7'd0, uio_out[0]}, 8'd1);
`else
        step(1'b1, gen_next(), 1'b1, "pre_clear");
        for (int i = 0; i < 36; i++) begin
            b = gen_next();
            step(1'b1, b ^ (i % 5 == 0), 1'b0, "burst");
        end
        chk("burst_state", {6'd0, uio_out[3:2]}, 8'd0);
        chk("burst_uo", uo_out, 8'd8);
        for (int i = 0; i < 22; i++) step(1'b1, gen_next(), 1'b0, "relock");
        chk("relock_pre", {7'd0, uio_out[0]}, 8'd0);
        step(1'b1, gen_next(), 1'b0, "relock");
        chk("relock_locked", {7'd0, uio_out[0]}, 8'd1);
        for (int i = 0; i < 128; i++) begin
            b = gen_next();
            step(1'b1, b ^ ((i % 64) < 63 && (i % 64) % 9 == 0), 1'b0, "seven_per_window");
        end
        chk("window_held", {7'd0, uio_out[0]}, 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
